// File: rtl/present_sched_if.sv
// Requester-side bundle for present_sched: encrypt request and ciphertext response.
// master = requester (drives req_valid/key/block/rsp_ready), slave = scheduler.
interface present_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [79:0] key;
    logic [63:0] block;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;

    modport master (
        output req_valid, key, block, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, key, block, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/present_sched.sv
// Round-robin scheduler of two requesters (a, b) onto one PRESENT-80 core.
// Ports: clk, n_reset (async low), a/b requester bundles, core_pl/core_in_text
// load bus, core_ciphertext/core_done result, busy (not idle).
module present_sched #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic           clk,
    input  logic           n_reset,
    present_sched_if.slave a,
    present_sched_if.slave b,
    output logic [1:0]     core_pl,
    output logic [79:0]    core_in_text,
    input  logic [63:0]    core_ciphertext,
    input  logic           core_done,
    output logic           busy
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD_KEY,
        LOAD_BLK,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [79:0] key_q;
    logic [63:0] blk_q;
    logic [79:0] cached_key;
    logic        key_valid;
    logic        owner;
    logic        last_grant;
    logic        a_rsp_v;
    logic        b_rsp_v;
    logic [63:0] a_rsp_d;
    logic [63:0] b_rsp_d;

    logic        elig_a;
    logic        elig_b;
    logic        grant_a;
    logic        grant_b;
    logic        accept;
    logic        key_hit;
    logic [79:0] sel_key;
    logic [63:0] sel_blk;

    // Eligibility uses the registered rsp_valid, so a response that is
    // being consumed this cycle still blocks a new grant to its owner.
    assign elig_a  = a.req_valid & ~a_rsp_v;
    assign elig_b  = b.req_valid & ~b_rsp_v;
    // last_grant = 1 means b was served last, so a wins a tie.
    assign grant_a = elig_a & (~elig_b | last_grant);
    assign grant_b = elig_b & ~grant_a;
    assign accept  = (state == IDLE) & (grant_a | grant_b);
    assign sel_key = grant_b ? b.key : a.key;
    assign sel_blk = grant_b ? b.block : a.block;
    assign key_hit = KEY_CACHE && key_valid && (sel_key == cached_key);

    assign a.req_ready = accept & grant_a;
    assign b.req_ready = accept & grant_b;
    assign a.rsp_valid = a_rsp_v;
    assign b.rsp_valid = b_rsp_v;
    assign a.rsp_data  = a_rsp_d;
    assign b.rsp_data  = b_rsp_d;
    assign busy        = (state != IDLE);

    always_comb begin
        state_nx     = state;
        core_pl      = 2'b00;
        core_in_text = 80'h0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = key_hit ? LOAD_BLK : LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                core_pl      = 2'b10;
                core_in_text = key_q;
                state_nx     = LOAD_BLK;
            end
            LOAD_BLK: begin
                core_pl      = 2'b01;
                core_in_text = {16'h0, blk_q};
                state_nx     = RUN;
            end
            RUN: begin
                if (core_done) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            key_q      <= 80'h0;
            blk_q      <= 64'h0;
            cached_key <= 80'h0;
            key_valid  <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            a_rsp_v    <= 1'b0;
            b_rsp_v    <= 1'b0;
            a_rsp_d    <= 64'h0;
            b_rsp_d    <= 64'h0;
        end else begin
            state <= state_nx;
            if (accept) begin
                key_q <= sel_key;
                blk_q <= sel_blk;
                owner <= grant_b;
            end
            if (state == LOAD_KEY) begin
                cached_key <= key_q;
                key_valid  <= 1'b1;
            end
            if (a_rsp_v && a.rsp_ready) begin
                a_rsp_v <= 1'b0;
            end
            if (b_rsp_v && b.rsp_ready) begin
                b_rsp_v <= 1'b0;
            end
            if (state == RUN && core_done) begin
                last_grant <= owner;
                if (owner) begin
                    b_rsp_v <= 1'b1;
                    b_rsp_d <= core_ciphertext;
                end else begin
                    a_rsp_v <= 1'b1;
                    a_rsp_d <= core_ciphertext;
                end
            end
        end
    end
endmodule

// File: doc/present_sched.md
# present_sched

Two-requester scheduler for the shared PRESENT-80 encryption core (`present_encoder`). It arbitrates encryption requests from requesters A and B round-robin. For each granted request it drives the core's load strobes: key load, then block load. It waits for the core's `done`, then returns the ciphertext to the owning requester through a per-requester response register. It also skips the key-load cycle when the requested key equals the key already held in the core.

## Interface
- `KEY_CACHE`, default 1: 1 enables the key-load skip; 0 always issues a key load.
- `clk`  in  1  clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset. The same net resets the core.
- `a_req_valid` / `b_req_valid`  in  1  request pending; holds until accepted.
- `a_req_ready` / `b_req_ready`  out  1  request accepted this cycle.
- `a_key` / `b_key`  in  80  encryption key; stable while valid.
- `a_block` / `b_block`  in  64  plaintext; stable while valid.
- `a_rsp_valid` / `b_rsp_valid`  out  1  ciphertext available.
- `a_rsp_ready` / `b_rsp_ready`  in  1  requester consumes the response.
- `a_rsp_data` / `b_rsp_data`  out  64  ciphertext.
- `core_pl`  out  2  core load strobes: `[1]` loads key, `[0]` loads block.
- `core_in_text`  out  80  core load data.
- `core_ciphertext`  in  64  core result, valid while `core_done`.
- `core_done`  in  1  core finished, 31 rounds after the block load.
- `busy`  out  1  FSM not in IDLE.

## Operation
**FSM states.** IDLE, LOAD_KEY, LOAD_BLK, RUN.

**IDLE**
- A requester is eligible when its `req_valid`=1 and its `rsp_valid`=0.
- If both are eligible, grant the one not granted last. `last_grant` resets to B, so A wins the first tie.
- The winner's `req_ready`=1 for exactly that cycle (combinational, IDLE only).
- Latch key, block and owner.
- Next state is LOAD_BLK if `KEY_CACHE`=1, `key_valid`=1 and the latched key equals `cached_key`. Otherwise next state is LOAD_KEY.

**LOAD_KEY** (1 cycle)
- `core_pl`=2'b10, `core_in_text`=key.
- Set `cached_key`=key and `key_valid`=1.
- Go to LOAD_BLK.

**LOAD_BLK** (1 cycle)
- `core_pl`=2'b01, `core_in_text`={16'h0, block}.
- Go to RUN.

**RUN**
- `core_pl`=0.
- When `core_done`=1: capture `core_ciphertext` into the owner's `rsp_data`, set the owner's `rsp_valid`, update `last_grant`, go to IDLE.

**Core-facing rules**
- `core_pl`=0 and `core_in_text`=0 in all other states.
- Key and block loads are never issued in the same cycle; the core shares one input bus for both.
- Loads are issued only in LOAD_KEY and LOAD_BLK. Those states are reached only from IDLE, after reset or after `done`, so the core is always able to accept the load.

**Response handshake**
- `rsp_valid` holds with `rsp_data` stable until `rsp_ready`=1; it clears on that edge.
- A requester with `rsp_valid`=1 is not eligible. Its response clearing and a new grant to it can occur on the same edge only if `rsp_ready` is sampled in IDLE before eligibility is evaluated. Do not do this: eligibility uses the registered `rsp_valid`.
- The other requester may be served while one response is pending.

**Reset values**
- State IDLE.
- All `req_ready`, `rsp_valid` and `busy` = 0; `rsp_data` = 0.
- `core_pl`=0, `core_in_text`=0.
- `key_valid`=0, `cached_key`=0, `last_grant`=B.
- Reset mid-operation aborts the encryption. No response is produced, and the request is not re-issued; the requester must re-present it.

## Timing
**Full load.** Accept in cycle 0 (IDLE). LOAD_KEY is cycle 1, LOAD_BLK cycle 2. Core counter=1 in cycle 3, and `core_done` is first high in cycle 34. The response is captured at the end of cycle 34, and `rsp_valid`=1 from cycle 35. Latency is 35 cycles from acceptance.

**Key cached.** One cycle shorter: `rsp_valid` from cycle 34.

**Back-to-back.** The earliest next acceptance is cycle 35 (IDLE). `core_done` stays high through IDLE, and the next LOAD clears it.

`busy`=1 in LOAD_KEY, LOAD_BLK and RUN.

## Test plan
- **Basic A request.** A: key=0, block=0 → `a_req_ready` in cycle 0; `a_rsp_valid` in cycle 35 with `a_rsp_data`=64'h5579C1387B228445. Check that `core_pl` sequence 10, 01 appears exactly once each.
- **Simultaneous requests after reset.** A (key=0, pt=0) and B (key=all-F, pt=0) valid together → A served first, then B. B gets 64'hE72C46C0F5945049. Then both valid again → A wins the next tie (B was granted last).
- **Key cache.** A key=0, pt=all-F twice in sequence → first response 64'hA112FFC72F68417B at latency 35. The second has no LOAD_KEY cycle and latency 34. With `KEY_CACHE`=0 both responses have latency 35.
- **Response backpressure.** Hold `a_rsp_ready`=0 → `a_rsp_data` stable and A not granted again. B's request with key=all-F, pt=all-F completes with 64'h3333DCD3213210D2 meanwhile.
- **Reset mid-RUN.** Assert `n_reset` in cycle 20 → all outputs at reset values immediately. After release, a new A request gets a full 35-cycle latency with LOAD_KEY present, since `key_valid` was cleared.
